sub_bytes_pipe: RTL and testbench
=================================

Name: sub_bytes_pipe

Overview:
Parametrised SubBytes stage for the AES datapath. Applies the forward S-box, or the inverse S-box when mode selects it, to every byte of an N-byte state. Output passes through a configurable-depth register pipeline with full valid/ready backpressure. Sits between AddRoundKey and ShiftRows in the round pipeline. The previous fixed 128-bit, single-register, enable-gated stage had no flow control and no inverse path.

Parameters:
NBYTES, 16, number of state bytes processed in parallel (1..32); state width W = 8*NBYTES
STAGES, 1, pipeline register depth (1..4); zero-stall latency in cycles

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
valid_i  input  1  input beat valid
ready_o  output  1  stage can accept a beat this cycle
dec_i  input  1  0 = forward S-box, 1 = inverse S-box; sampled with the beat
state_i  input  W  input state; byte k at [8k+7:8k]
valid_o  output  1  output beat valid
ready_i  input  1  downstream accepts output
dec_o  output  1  mode travelling with the output beat
state_o  output  W  substituted state

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst). All registers update on posedge clk only.
- Reset (rst=1 at a clock edge): every stage valid bit cleared to 0. Every stage data and mode register cleared to 0. Outputs: valid_o=0, state_o=0, dec_o=0. ready_o=1 combinationally while all stages are empty. Reset mid-stream discards all in-flight beats; no partial output.
- Substitution: combinational, byte-wise, applied to state_i before stage 1 is written. Byte k of the output is S(state_i byte k), or InvS(byte k) when dec_i=1. No inter-byte mixing, so byte order is preserved. Stages 2..STAGES are pure delay.
- Handshake: input transfer when valid_i && ready_o. Output transfer when valid_o && ready_i.
- valid_o, state_o and dec_o come directly from the last stage registers (registered outputs).
- Stage s advance: stage s loads from stage s-1 (stage 0 = input) when stage s is empty, or when stage s+1 can accept its contents (for the last stage: ready_i=1).
- ready_o = stage-1 advance condition. This is combinational from ready_i through the stage valid bits; there is no skid buffer.
- Throughput: one beat per cycle while ready_i=1.
- Zero-stall latency: a beat accepted at edge t appears on valid_o in the cycle after edge t+STAGES-1 (STAGES=1: visible in the cycle after acceptance).
- Stall: while valid_o=1 and ready_i=0, state_o and dec_o hold stable. Stages fill from the output backward; ready_o drops once all STAGES slots hold valid beats.
- Full, simultaneous: with the pipeline full, ready_i=1 and valid_i=1 in the same cycle, the output beat leaves and the new beat enters in one edge. ready_o is 1 in that cycle.
- Empty: valid_o=0; state_o holds its last value and is don't-care for checking.
- Mode: dec_i may change beat-to-beat. Each beat carries its own dec bit to dec_o, which must match the originating dec_i.
- Ordering: beats emerge in acceptance order, none dropped or duplicated.
- Assertions: state_o stable while valid_o && !ready_i; valid_o never rises within STAGES-1 cycles after a reset release.

Optional Feature:
SUB_BYTES_INV_EN.
- Defined: the inverse S-box table is instantiated per byte, and dec_i selects forward or inverse per beat as described above.
- Undefined: no inverse table; the forward S-box is always applied regardless of dec_i. dec_i still propagates to dec_o unchanged, so interface timing is identical. Intended for encrypt-only builds to save area.

Test Plan:
- FIPS-197 vector: NBYTES=16, STAGES=1, dec_i=0, state_i=0x193de3bea0f4e22b9ac68d2ae9f84808, ready_i=1 -> one cycle later valid_o=1, state_o=0xd42711aee0bf98f1b8b45de51e415230, dec_o=0.
- Inverse vector (SUB_BYTES_INV_EN defined): dec_i=1, state_i=0xd42711aee0bf98f1b8b45de51e415230 -> state_o=0x193de3bea0f4e22b9ac68d2ae9f84808, dec_o=1. With the macro undefined, the same stimulus -> forward S-box result, dec_o=1.
- Latency and streaming: STAGES=3, 10 back-to-back beats, bytes all 0x00, 0x53, 0x63, ... alternating; ready_i=1 -> first valid_o exactly 3 cycles after first accept, then 10 consecutive beats with 0x00->0x63 and 0x53->0xED, in order.
- Backpressure: STAGES=2, ready_i=0 for 5 cycles with valid_i=1 -> ready_o=0 after 2 accepts. state_o stays constant while stalled. On ready_i=1, all beats drain in order, none lost or duplicated. Random ready_i toggling over 1000 beats matches a scoreboard.
- Mixed mode per beat (SUB_BYTES_INV_EN): alternating dec_i 0/1 on bytes 0x00 -> outputs alternate 0x63..63 and 0x52..52, with dec_o matching.
- Reset mid-operation: rst=1 for 1 cycle with a full pipeline and ready_i=0 -> next cycle valid_o=0, state_o=0, ready_o=1. No pre-reset beat appears afterward; a new beat then completes with normal latency.

Source files
------------

// File: rtl/sub_bytes_pipe.sv
// AES SubBytes stage: per-byte S-box followed by a STAGES-deep valid/ready register pipeline.
// Optional macro SUB_BYTES_INV_EN adds the inverse S-box, selected per beat by dec_i.
module sub_bytes_pipe #(
    parameter int NBYTES = 16,
    parameter int STAGES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic                dec_i,
    input  logic [8*NBYTES-1:0] state_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                dec_o,
    output logic [8*NBYTES-1:0] state_o
);
    localparam int W = 8 * NBYTES;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? x : 8'h00);
            x   = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = a;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

`ifdef SUB_BYTES_INV_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] y;
        y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction
`endif

    logic [W-1:0]      sub_s;
    logic [STAGES-1:0] adv_s;
    logic [STAGES-1:0] in_valid_s;
    logic [STAGES-1:0] in_dec_s;
    logic [W-1:0]      in_data_s [STAGES];
    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] dec_r;
    logic [W-1:0]      data_r [STAGES];

    // Byte-wise substitution of the incoming state
    always_comb begin
        sub_s = '0;
        for (int k = 0; k < NBYTES; k++) begin
`ifdef SUB_BYTES_INV_EN
            sub_s[8*k +: 8] = dec_i ? inv_sbox(state_i[8*k +: 8]) : fwd_sbox(state_i[8*k +: 8]);
`else
            sub_s[8*k +: 8] = fwd_sbox(state_i[8*k +: 8]);
`endif
        end
    end

    // Advance chain: a stage loads when empty or when the stage after it loads
    always_comb begin
        logic nxt_s;
        adv_s = '0;
        nxt_s = ready_i;
        for (int s = STAGES - 1; s >= 0; s--) begin
            adv_s[s] = !valid_r[s] || nxt_s;
            nxt_s    = adv_s[s];
        end
    end

    assign in_valid_s[0] = valid_i;
    assign in_dec_s[0]   = dec_i;
    assign in_data_s[0]  = sub_s;

    for (genvar s = 1; s < STAGES; s++) begin : g_chain
        assign in_valid_s[s] = valid_r[s-1];
        assign in_dec_s[s]   = dec_r[s-1];
        assign in_data_s[s]  = data_r[s-1];
    end

    // Stage registers; payload only captured with a valid beat so an empty output holds
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            dec_r   <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_r[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (adv_s[s]) begin
                    valid_r[s] <= in_valid_s[s];
                    if (in_valid_s[s]) begin
                        data_r[s] <= in_data_s[s];
                        dec_r[s]  <= in_dec_s[s];
                    end
                end
            end
        end
    end

    assign ready_o = adv_s[0];
    assign valid_o = valid_r[STAGES-1];
    assign dec_o   = dec_r[STAGES-1];
    assign state_o = data_r[STAGES-1];

    sub_bytes_pipe_chk #(.W(W), .STAGES(STAGES)) u_chk (
        .clk   (clk),
        .rst   (rst),
        .valid (valid_o),
        .ready (ready_i),
        .state (state_o)
    );
endmodule

// Output-side properties: stable data under stall, no early valid after reset release.
module sub_bytes_pipe_chk #(
    parameter int W      = 128,
    parameter int STAGES = 1
) (
    input logic         clk,
    input logic         rst,
    input logic         valid,
    input logic         ready,
    input logic [W-1:0] state
);
    logic         stall_r;
    logic [W-1:0] held_r;
    logic [2:0]   since_rst_r;

    // History of the previous cycle and edges elapsed since reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_r     <= 1'b0;
            held_r      <= '0;
            since_rst_r <= 3'd0;
        end else begin
            stall_r <= valid && !ready;
            held_r  <= state;
            if (since_rst_r != 3'd7) begin
                since_rst_r <= since_rst_r + 3'd1;
            end
        end
    end

    // Property evaluation
    always @(posedge clk) begin
        if (!rst) begin
            assert (!stall_r || state == held_r);
            assert (!valid || int'(since_rst_r) >= STAGES);
        end
    end
endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Directed bench for sub_bytes_pipe: three instances (STAGES 1, 2, 3) exercised in turn.
module tb_sub_bytes_pipe;
`ifdef SUB_BYTES_INV_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic         clk;
    logic         rst;
    logic [2:0]   valid_i;
    logic [2:0]   ready_i;
    logic [2:0]   ready_o;
    logic [2:0]   valid_o;
    logic [2:0]   dec_o;
    logic         dec_i;
    logic [127:0] state_i;
    logic [127:0] state_o [3];

    logic [7:0]   fwd_in  [8] = '{8'h19, 8'h3d, 8'he3, 8'hbe, 8'ha0, 8'hf4, 8'he2, 8'h2b};
    logic [7:0]   fwd_out [8] = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1};

    int           errors = 0;
    int           checks = 0;
    logic [128:0] q [$];

    sub_bytes_pipe #(.NBYTES(16), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .valid_i(valid_i[0]), .ready_o(ready_o[0]), .dec_i(dec_i),
        .state_i(state_i), .valid_o(valid_o[0]), .ready_i(ready_i[0]), .dec_o(dec_o[0]),
        .state_o(state_o[0]));
    sub_bytes_pipe #(.NBYTES(16), .STAGES(2)) u_s2 (
        .clk(clk), .rst(rst), .valid_i(valid_i[1]), .ready_o(ready_o[1]), .dec_i(dec_i),
        .state_i(state_i), .valid_o(valid_o[1]), .ready_i(ready_i[1]), .dec_o(dec_o[1]),
        .state_o(state_o[1]));
    sub_bytes_pipe #(.NBYTES(16), .STAGES(3)) u_s3 (
        .clk(clk), .rst(rst), .valid_i(valid_i[2]), .ready_o(ready_o[2]), .dec_i(dec_i),
        .state_i(state_i), .valid_o(valid_o[2]), .ready_i(ready_i[2]), .dec_o(dec_o[2]),
        .state_o(state_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Beat idx selects one known S-box pair per byte; inverse beats swap the roles
    function automatic logic [127:0] beat_data(input int idx, input bit dec, input bit want_out);
        logic [127:0] v;
        int d;
        v = '0;
        for (int k = 0; k < 16; k++) begin
            d = (idx >> (3 * (k % 4))) & 7;
            v[8*k +: 8] = ((dec && INV) ^ want_out) ? fwd_out[d] : fwd_in[d];
        end
        return v;
    endfunction

    initial begin
        int sent;
        int rcvd;
        int cyc;
        logic [128:0] exp_beat;
        bit d;

        rst = 1'b1; valid_i = 3'b000; ready_i = 3'b111; dec_i = 1'b0; state_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("rst_valid", valid_o[i], 1'b0);
            check_val("rst_state", state_o[i], 128'h0);
            check_val("rst_dec", dec_o[i], 1'b0);
            check_val("rst_ready", ready_o[i], 1'b1);
        end

        // FIPS-197 forward vector, STAGES=1
        valid_i[0] = 1'b1; dec_i = 1'b0; state_i = FIPS_IN;
        #1 check_val("fips_ready", ready_o[0], 1'b1);
        @(negedge clk);
        valid_i[0] = 1'b0;
        check_val("fips_valid", valid_o[0], 1'b1);
        check_val("fips_state", state_o[0], FIPS_OUT);
        check_val("fips_dec", dec_o[0], 1'b0);
        @(negedge clk);
        check_val("fips_single", valid_o[0], 1'b0);

        // dec=1: inverse result when built with the inverse table, forward otherwise
        valid_i[0] = 1'b1; dec_i = 1'b1; state_i = INV ? FIPS_OUT : FIPS_IN;
        @(negedge clk);
        valid_i[0] = 1'b0;
        check_val("inv_valid", valid_o[0], 1'b1);
        check_val("inv_state", state_o[0], INV ? FIPS_IN : FIPS_OUT);
        check_val("inv_dec", dec_o[0], 1'b1);

        // Mixed mode per beat on zero bytes
        for (int n = 0; n < 4; n++) begin
            d = (n % 2 == 1);
            valid_i[0] = 1'b1; dec_i = d; state_i = '0;
            @(negedge clk);
            check_val("mix_valid", valid_o[0], 1'b1);
            check_val("mix_state", state_o[0], (d && INV) ? {16{8'h52}} : {16{8'h63}});
            check_val("mix_dec", dec_o[0], d);
        end
        valid_i[0] = 1'b0; dec_i = 1'b0;
        @(negedge clk);
        check_val("mix_idle", valid_o[0], 1'b0);

        // Streaming latency, STAGES=3, 10 beats alternating 0x00 / 0x53
        for (int n = 0; n < 14; n++) begin
            valid_i[2] = (n < 10);
            state_i = (n % 2 == 1) ? {16{8'h53}} : 128'h0;
            #1 check_val("lat_ready", ready_o[2], 1'b1);
            @(negedge clk);
            check_val("lat_valid", valid_o[2], (n >= 2 && n < 12));
            if (n >= 2 && n < 12)
                check_val("lat_state", state_o[2], ((n - 2) % 2 == 1) ? {16{8'hed}} : {16{8'h63}});
        end
        valid_i[2] = 1'b0;

        // Backpressure, STAGES=2: fill under stall then drain
        q.delete();
        sent = 0;
        ready_i[1] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            valid_i[1] = 1'b1; dec_i = 1'b0; state_i = beat_data(sent, 1'b0, 1'b0);
            #1 check_val("bp_ready", ready_o[1], (c < 2));
            if (c >= 2) begin
                check_val("bp_hold_valid", valid_o[1], 1'b1);
                check_val("bp_hold_state", state_o[1], beat_data(0, 1'b0, 1'b1));
            end
            if (ready_o[1]) begin
                q.push_back({1'b0, beat_data(sent, 1'b0, 1'b1)});
                sent++;
            end
            @(negedge clk);
        end
        valid_i[1] = 1'b0; ready_i[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (valid_o[1]) begin
                check_val("bp_nonempty", 129'(q.size() != 0), 129'd1);
                exp_beat = (q.size() != 0) ? q.pop_front() : 129'h0;
                check_val("bp_drain", {dec_o[1], state_o[1]}, exp_beat);
            end
            @(negedge clk);
        end
        check_val("bp_left", 129'(q.size()), 129'd0);
        check_val("bp_sent", 129'(sent), 129'd2);

        // Random ready/valid over 1000 beats against the scoreboard
        sent = 0; rcvd = 0; cyc = 0;
        while ((rcvd < 1000) && (cyc < 20000)) begin
            ready_i[1] = 1'($urandom_range(0, 1));
            valid_i[1] = (sent < 1000) && ($urandom_range(0, 3) != 0);
            dec_i = 1'($urandom_range(0, 1));
            state_i = beat_data(sent, dec_i, 1'b0);
            #1;
            if (valid_o[1] && ready_i[1]) begin
                check_val("rnd_nonempty", 129'(q.size() != 0), 129'd1);
                exp_beat = (q.size() != 0) ? q.pop_front() : 129'h0;
                check_val("rnd_beat", {dec_o[1], state_o[1]}, exp_beat);
                rcvd++;
            end
            if (valid_i[1] && ready_o[1]) begin
                q.push_back({dec_i, beat_data(sent, dec_i, 1'b1)});
                sent++;
            end
            cyc++;
            @(negedge clk);
        end
        valid_i[1] = 1'b0;
        check_val("rnd_rcvd", 129'(rcvd), 129'd1000);
        check_val("rnd_left", 129'(q.size()), 129'd0);

        // Reset with a full stalled pipeline, then one fresh beat
        ready_i[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            valid_i[1] = 1'b1; dec_i = 1'b1; state_i = beat_data(20 + c, 1'b1, 1'b0);
            @(negedge clk);
        end
        check_val("mr_full", ready_o[1], 1'b0);
        valid_i[1] = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mr_valid", valid_o[1], 1'b0);
        check_val("mr_state", state_o[1], 128'h0);
        check_val("mr_dec", dec_o[1], 1'b0);
        check_val("mr_ready", ready_o[1], 1'b1);
        ready_i[1] = 1'b1; valid_i[1] = 1'b1; dec_i = 1'b0; state_i = beat_data(5, 1'b0, 1'b0);
        @(negedge clk);
        valid_i[1] = 1'b0;
        check_val("mr_lat0", valid_o[1], 1'b0);
        @(negedge clk);
        check_val("mr_lat1", valid_o[1], 1'b1);
        check_val("mr_new", {dec_o[1], state_o[1]}, {1'b0, beat_data(5, 1'b0, 1'b1)});
        @(negedge clk);
        check_val("mr_after", valid_o[1], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1);
    end
endmodule
